// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the RV32I ALU decoder
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
endpackage

// File: rtl/alu_deco_comb.sv
// alu_deco_comb: combinational aluOp/funct decode to ALU select and illegal flag
module alu_deco_comb
  import alu_pkg::*;
(
  input  logic       op,
  input  logic       f7,
  input  logic [2:0] f3,
  input  logic [1:0] aluOp,
  output logic [2:0] ctrlNext,
  output logic       illegalNext
);
  always_comb begin
    ctrlNext = ALU_ADD;
    illegalNext = 1'b0;
    case (aluOp)
      ALUOP_ADD: ctrlNext = ALU_ADD;
      ALUOP_SUB: ctrlNext = ALU_SUB;
      ALUOP_FUNCT:
        case (f3)
          // op gates f7 so ADDI with an immediate bit set never becomes SUB
          F3_ADDSUB: ctrlNext = (op & f7) ? ALU_SUB : ALU_ADD;
          F3_SLT:    ctrlNext = ALU_SLT;
          F3_OR:     ctrlNext = ALU_OR;
          F3_AND:    ctrlNext = ALU_AND;
          default:   illegalNext = 1'b1;
        endcase
      ALUOP_RSVD: illegalNext = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_deco.sv
// alu_deco: registered RV32I ALU decoder
module alu_deco
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       op,
  input  logic       f7,
  input  logic [2:0] f3,
  input  logic [1:0] aluOp,
  output logic [2:0] aluControl,
  output logic       illegal
);
  logic [2:0] ctrlNext;
  logic       illegalNext;
  alu_deco_comb uComb (
    .op(op),
    .f7(f7),
    .f3(f3),
    .aluOp(aluOp),
    .ctrlNext(ctrlNext),
    .illegalNext(illegalNext)
  );
  always_ff @(posedge clk) begin
    aluControl <= rst ? ALU_ADD : ctrlNext;
    illegal <= rst ? 1'b0 : illegalNext;
  end
endmodule

// File: tb/tb_alu_deco.sv
// tb_alu_deco: randomized scoreboard bench for alu_deco
module tb_alu_deco;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic op = 1'b0;
  logic f7 = 1'b0;
  logic [2:0] f3 = 3'b000;
  logic [1:0] aluOp = 2'b00;
  logic [2:0] aluControl;
  logic illegal;
  typedef struct {
    logic [2:0] ctrl;
    logic       ill;
    string      tag;
  } expT;
  expT sb[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  alu_deco dut (
    .clk(clk),
    .rst(rst),
    .op(op),
    .f7(f7),
    .f3(f3),
    .aluOp(aluOp),
    .aluControl(aluControl),
    .illegal(illegal)
  );
  // Reference: R-type funct table indexed by funct3; absent entries are unsupported
  function automatic expT model(input logic r, input logic o, input logic s7,
                                input logic [2:0] s3, input logic [1:0] a, input string tag);
    expT e;
    logic [2:0] tbl [8];
    logic       ok  [8];
    for (int i = 0; i < 8; i++) begin
      tbl[i] = 3'b000;
      ok[i] = 1'b0;
    end
    tbl[0] = (o && s7) ? 3'b001 : 3'b000; ok[0] = 1'b1;
    tbl[2] = 3'b101; ok[2] = 1'b1;
    tbl[6] = 3'b011; ok[6] = 1'b1;
    tbl[7] = 3'b010; ok[7] = 1'b1;
    e.tag = tag;
    e.ctrl = 3'b000;
    e.ill = 1'b0;
    if (!r) begin
      if (a == 2'd1) e.ctrl = 3'b001;
      else if (a == 2'd2) begin
        e.ctrl = tbl[s3];
        e.ill = !ok[s3];
      end
      else if (a == 2'd3) e.ill = 1'b1;
    end
    return e;
  endfunction
  task automatic step(input logic r, input logic o, input logic s7,
                      input logic [2:0] s3, input logic [1:0] a, input string tag);
    @(negedge clk);
    rst = r; op = o; f7 = s7; f3 = s3; aluOp = a;
    sb.push_back(model(r, o, s7, s3, a, tag));
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      expT e;
      e = sb.pop_front();
      total++;
      if (aluControl !== e.ctrl || illegal !== e.ill) begin
        bad++;
        $display("FAIL %s: got ctrl=%b illegal=%b, expected ctrl=%b illegal=%b",
                 e.tag, aluControl, illegal, e.ctrl, e.ill);
      end
    end
  end
  initial begin
    step(1, 0, 0, 3'b010, 2'b10, "reset0");
    step(1, 0, 0, 3'b010, 2'b10, "reset1");
    step(0, 0, 0, 3'b000, 2'b10, "add");
    step(0, 1, 1, 3'b000, 2'b10, "sub");
    step(0, 0, 1, 3'b000, 2'b10, "addi_f7");
    step(0, 1, 0, 3'b000, 2'b10, "add_r");
    step(0, 1'($urandom), 1'($urandom), 3'($urandom), 2'b00, "aluop_add");
    step(0, 1'($urandom), 1'($urandom), 3'($urandom), 2'b01, "aluop_sub");
    step(0, 0, 0, 3'b010, 2'b10, "slt");
    step(0, 0, 0, 3'b110, 2'b10, "or");
    step(0, 0, 0, 3'b111, 2'b10, "and");
    step(0, 1, 0, 3'b001, 2'b10, "sll_ill");
    step(0, 1, 0, 3'b011, 2'b10, "sltu_ill");
    step(0, 1, 0, 3'b100, 2'b10, "xor_ill");
    step(0, 1, 1, 3'b101, 2'b10, "sra_ill");
    step(0, 0, 0, 3'b010, 2'b11, "rsvd");
    step(1, 1, 1, 3'b000, 2'b10, "mid_reset");
    step(0, 1, 1, 3'b000, 2'b10, "resume");
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
           3'($urandom), 2'($urandom), "random");
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
